// File: rtl/elink_trig_voter_tmr.sv
// TMR majority voter for one e-link trigger word: bitwise 2-of-3 vote plus fault flags.
// Optional per-lane mismatch counters are built when ELINK_VOTER_ERRCNT_EN is defined.
module elink_trig_voter_tmr #(
  parameter int unsigned DATA_W = 12
`ifdef ELINK_VOTER_ERRCNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic [DATA_W+1:0] voted
`ifdef ELINK_VOTER_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt1,
  output logic [CNT_W-1:0]  err_cnt2,
  output logic [CNT_W-1:0]  err_cnt3
`endif
);

  logic [DATA_W-1:0] maj_c;
  logic              d1_c;
  logic              d2_c;
  logic              d3_c;
  logic              fault_c;
  logic              multi_c;

  // Bitwise vote and per-lane disagreement with the voted word
  always_comb begin
    maj_c   = (data_in1 & data_in2) | (data_in1 & data_in3) | (data_in2 & data_in3);
    d1_c    = |(data_in1 ^ maj_c);
    d2_c    = |(data_in2 ^ maj_c);
    d3_c    = |(data_in3 ^ maj_c);
    fault_c = d1_c | d2_c | d3_c;
    multi_c = (d1_c & d2_c) | (d1_c & d3_c) | (d2_c & d3_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted <= '0;
    end else begin
      voted <= {multi_c, fault_c, maj_c};
    end
  end

`ifdef ELINK_VOTER_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating mismatch counters; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt1 <= '0;
      err_cnt2 <= '0;
      err_cnt3 <= '0;
    end else begin
      if (d1_c && (err_cnt1 != CNT_MAX)) err_cnt1 <= err_cnt1 + CNT_W'(1);
      if (d2_c && (err_cnt2 != CNT_MAX)) err_cnt2 <= err_cnt2 + CNT_W'(1);
      if (d3_c && (err_cnt3 != CNT_MAX)) err_cnt3 <= err_cnt3 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_elink_trig_voter_tmr.sv
// Self-checking bench for elink_trig_voter_tmr: directed vectors, reset behaviour and
// randomized lanes against a bit-counting reference model (counters when ELINK_VOTER_ERRCNT_EN).
module tb_elink_trig_voter_tmr;

  localparam int DW   = 12;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in1;
  logic [DW-1:0] data_in2;
  logic [DW-1:0] data_in3;
  logic [DW+1:0] voted;
`ifdef ELINK_VOTER_ERRCNT_EN
  logic [CW-1:0] err_cnt1;
  logic [CW-1:0] err_cnt2;
  logic [CW-1:0] err_cnt3;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int mdl_cnt [3];

`ifdef ELINK_VOTER_ERRCNT_EN
  elink_trig_voter_tmr #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .voted(voted),
    .err_cnt1(err_cnt1), .err_cnt2(err_cnt2), .err_cnt3(err_cnt3)
  );
`else
  elink_trig_voter_tmr #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .voted(voted)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: count votes per bit, then compare each lane against the result
  function automatic logic [DW+1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c, output int dv [3]);
    logic [DW-1:0] m;
    int nbad;
    m = '0;
    for (int i = 0; i < DW; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      m[i] = (ones >= 2);
    end
    dv[0] = (a != m) ? 1 : 0;
    dv[1] = (b != m) ? 1 : 0;
    dv[2] = (c != m) ? 1 : 0;
    nbad = dv[0] + dv[1] + dv[2];
    return {(nbad >= 2), (nbad >= 1), m};
  endfunction

  task automatic check_cnts(input string tag);
`ifdef ELINK_VOTER_ERRCNT_EN
    check({tag, "_cnt1"}, 32'(err_cnt1), 32'(mdl_cnt[0]));
    check({tag, "_cnt2"}, 32'(err_cnt2), 32'(mdl_cnt[1]));
    check({tag, "_cnt3"}, 32'(err_cnt3), 32'(mdl_cnt[2]));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Drive one word on all lanes, clock it through, and return the model's expectation
  task automatic step(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                      output logic [DW+1:0] exp);
    int dv [3];
    data_in1 = a;
    data_in2 = b;
    data_in3 = c;
    exp = model(a, b, c, dv);
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++)
      if (dv[n] != 0 && mdl_cnt[n] < CMAX) mdl_cnt[n]++;
  endtask

  task automatic clear_model();
    for (int n = 0; n < 3; n++) mdl_cnt[n] = 0;
  endtask

  initial begin
    logic [DW+1:0] exp;
    logic [DW-1:0] base;
    logic [DW-1:0] lane [3];

    clear_model();
    rst_n = 1'b0;
    data_in1 = 12'h5A5;
    data_in2 = 12'h3C3;
    data_in3 = 12'hF0F;
    #3;
    check("reset_voted", 32'(voted), 32'h0);
    check_cnts("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with literal expectations
    step(12'hFFF, 12'hFFF, 12'hFFF, exp);
    check("all_equal", 32'(voted), 32'h0FFF);
    check_cnts("all_equal");
    step(12'h000, 12'hFFF, 12'hFFF, exp);
    check("lane1_out", 32'(voted), 32'h1FFF);
    check_cnts("lane1_out");
    step(12'h000, 12'h000, 12'hFFF, exp);
    check("lane3_out", 32'(voted), 32'h1000);
    step(12'h007, 12'h000, 12'hFFF, exp);
    check("multi_fault", 32'(voted), 32'h3007);
    check_cnts("multi_fault");
    step(12'hABC, 12'hABC, 12'hABC, exp);
    check("all_equal_abc", 32'(voted), 32'h0ABC);

    // Asynchronous reset mid-cycle, then recovery after one edge
    data_in1 = 12'h123;
    data_in2 = 12'h456;
    data_in3 = 12'h789;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(voted), 32'h0);
    clear_model();
    check_cnts("async_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(12'h800, 12'h801, 12'h800, exp);
    check("post_reset", 32'(voted), 32'(exp));
    check("post_reset_lit", 32'(voted), 32'h1800);

`ifdef ELINK_VOTER_ERRCNT_EN
    // Saturation: lane 1 out-voted for five cycles from a clean reset
    rst_n = 1'b0;
    #1;
    clear_model();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(12'h000, 12'hFFF, 12'hFFF, exp);
    check("sat_cnt1", 32'(err_cnt1), 32'd3);
    check("sat_cnt2", 32'(err_cnt2), 32'd0);
    check("sat_cnt3", 32'(err_cnt3), 32'd0);
    rst_n = 1'b0;
    #1;
    clear_model();
    rst_n = 1'b1;
`endif

    // Randomized lanes: a shared base word with sparse per-lane corruption
    for (int it = 0; it < 300; it++) begin
      base = DW'($urandom);
      for (int n = 0; n < 3; n++) begin
        lane[n] = base;
        if ($urandom_range(0, 3) == 0) lane[n] = base ^ DW'(1 << $urandom_range(0, DW - 1));
        if ($urandom_range(0, 9) == 0) lane[n] = DW'($urandom);
      end
      step(lane[0], lane[1], lane[2], exp);
      check($sformatf("rand_%0d", it), 32'(voted), 32'(exp));
      check_cnts($sformatf("rand_%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
